// File: rtl/time_set_ctrl.sv
// Alarm-clock control sequencer: debounces the manual buttons, selects RUN/TSET/ASET,
// steers count enables to the time counters and alarm registers, and times the buzz.
module time_set_ctrl #(
  parameter int DB_CYC   = 2,
  parameter int BUZZ_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timeset,
  input  logic       alarmset,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       alarmon,
  input  logic       szero,
  input  logic       mzero,
  input  logic       match,
  output logic       tmen,
  output logic       then,
  output logic       amen,
  output logic       ahen,
  output logic [1:0] mode,
  output logic       buzz
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TSET = 2'b01,
    ASET = 2'b10
  } mode_e;

  localparam logic [3:0] DB_LAST   = 4'(DB_CYC - 1);
  localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_LEN - 1);
  localparam int B_TS = 0;
  localparam int B_AS = 1;
  localparam int B_MA = 2;
  localparam int B_HA = 3;

  logic [3:0]      raw;
  logic [3:0]      db_q, db_d;
  logic [3:0][3:0] dbcnt_q, dbcnt_d;
  mode_e           mode_q, mode_d;
  logic            match_q, match_d;
  logic            buzz_q, buzz_d;
  logic [7:0]      bcnt_q, bcnt_d;
  logic            trig;

  assign raw = {hrsadv, minadv, alarmset, timeset};

  // Debounce: a button's level is accepted only after DB_CYC consecutive differing samples
  always_comb begin
    db_d    = db_q;
    dbcnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != db_q[i]) begin
        if (dbcnt_q[i] == DB_LAST) begin
          db_d[i] = raw[i];
        end else begin
          dbcnt_d[i] = dbcnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    mode_d = RUN;
    if (db_q[B_TS]) begin
      mode_d = TSET;
    end else if (db_q[B_AS]) begin
      mode_d = ASET;
    end
  end

  // Buzz: cancel by alarmon or leaving RUN wins over a fresh trigger, which reloads the timer
  always_comb begin
    match_d = match;
    buzz_d  = buzz_q;
    bcnt_d  = bcnt_q;
    trig    = match & ~match_q & alarmon & (mode_q == RUN);
    if (!alarmon) begin
      buzz_d = 1'b0;
      bcnt_d = 8'd0;
    end else if (buzz_q && (mode_q != RUN)) begin
      buzz_d = 1'b0;
      bcnt_d = 8'd0;
    end else if (trig) begin
      buzz_d = 1'b1;
      bcnt_d = BUZZ_LAST;
    end else if (buzz_q) begin
      if (bcnt_q == 8'd0) begin
        buzz_d = 1'b0;
      end else begin
        bcnt_d = bcnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      db_q    <= '0;
      dbcnt_q <= '0;
      mode_q  <= RUN;
      match_q <= 1'b0;
      buzz_q  <= 1'b0;
      bcnt_q  <= 8'd0;
    end else begin
      db_q    <= db_d;
      dbcnt_q <= dbcnt_d;
      mode_q  <= mode_d;
      match_q <= match_d;
      buzz_q  <= buzz_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Enables follow the registered mode, so a mode switch never glitches a counter
  always_comb begin
    tmen = 1'b0;
    then = 1'b0;
    amen = 1'b0;
    ahen = 1'b0;
    case (mode_q)
      TSET: begin
        tmen = db_q[B_MA];
        then = db_q[B_HA];
      end
      ASET: begin
        tmen = szero;
        then = szero & mzero;
        amen = db_q[B_MA];
        ahen = db_q[B_HA];
      end
      default: begin
        tmen = szero;
        then = szero & mzero;
      end
    endcase
    if (!rst) begin
      tmen = 1'b0;
      then = 1'b0;
      amen = 1'b0;
      ahen = 1'b0;
    end
  end

  assign mode = mode_q;
  assign buzz = buzz_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl (DB_CYC=2, BUZZ_LEN=4) with a tagged expectation queue.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       timeset, alarmset, minadv, hrsadv;
  logic       alarmon, szero, mzero, match;
  logic       tmen, then, amen, ahen;
  logic [1:0] mode;
  logic       buzz;

  time_set_ctrl #(.DB_CYC(2), .BUZZ_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .timeset(timeset), .alarmset(alarmset), .minadv(minadv), .hrsadv(hrsadv),
    .alarmon(alarmon), .szero(szero), .mzero(mzero), .match(match),
    .tmen(tmen), .then(then), .amen(amen), .ahen(ahen),
    .mode(mode), .buzz(buzz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    tag;
    string nm;
    int    m;
    int    b;
    int    en;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string nm, input string f, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, f, act, req, cyc);
    end
  endtask

  // Expectation for the outputs seen just after the next rising edge; -1 skips a field
  task automatic chk(input string nm, input int m, input int b, input int en);
    exp_t e;
    e.tag = cyc + 1;
    e.nm  = nm;
    e.m   = m;
    e.b   = b;
    e.en  = en;
    q.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic clr();
    nx();
    rst = 1'b0; timeset = 1'b0; alarmset = 1'b0; minadv = 1'b0; hrsadv = 1'b0;
    match = 1'b0; szero = 1'b0; mzero = 1'b0; alarmon = 1'b1;
    chk("rst_clr", 0, 0, 4'b0000);
    nx();
    rst = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        if (e.m >= 0)  cmp(e.nm, "mode", int'(mode), e.m);
        if (e.b >= 0)  cmp(e.nm, "buzz", int'(buzz), e.b);
        if (e.en >= 0) cmp(e.nm, "en", int'({tmen, then, amen, ahen}), e.en);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    timeset = 1'b1; alarmset = 1'b1; minadv = 1'b1; hrsadv = 1'b1;
    alarmon = 1'b1; szero = 1'b1; mzero = 1'b1; match = 1'b0;

    // Reset with every button held, then release
    nx(); chk("rst_hold", 0, 0, 4'b0000);
    nx(); rst = 1'b1; szero = 1'b0; mzero = 1'b0; chk("rel1", 0, 0, 4'b0000);
    nx(); chk("rel2", 0, 0, 4'b0000);
    nx(); chk("rel3", 1, 0, 4'b1100);

    // Glitches shorter than DB_CYC, then a valid press
    clr();
    nx(); timeset = 1'b1; chk("gl1", 0, -1, -1);
    nx(); timeset = 1'b0; chk("gl2", 0, -1, -1);
    nx(); timeset = 1'b1; chk("gl3", 0, -1, -1);
    nx(); timeset = 1'b0; chk("gl4", 0, -1, -1);
    nx(); chk("gl5", 0, -1, -1);
    nx(); timeset = 1'b1; chk("db1", 0, -1, -1);
    nx(); chk("db2", 0, -1, -1);
    nx(); chk("db3", 1, -1, -1);

    // TSET: minadv held, carries ignored
    nx(); szero = 1'b1; mzero = 1'b1; minadv = 1'b1; chk("ts_ma0", 1, -1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      nx(); chk("ts_ma", 1, -1, 4'b1000);
    end
    nx(); minadv = 1'b0; chk("ts_rel0", 1, -1, 4'b1000);
    nx(); chk("ts_rel1", 1, -1, 4'b0000);

    // ASET: hrsadv drives ahen while tmen follows szero
    nx(); timeset = 1'b0; alarmset = 1'b1; mzero = 1'b0; chk("as0", 1, -1, 4'b0000);
    nx(); chk("as1", 1, -1, 4'b0000);
    nx(); hrsadv = 1'b1; chk("as2", 2, -1, 4'b1000);
    nx(); chk("as3", 2, -1, 4'b1001);
    nx(); szero = 1'b0; chk("as4", 2, -1, 4'b0001);
    nx(); szero = 1'b1; mzero = 1'b1; chk("as5", 2, -1, 4'b1101);

    // RUN carries
    clr();
    nx(); szero = 1'b1; mzero = 1'b0; chk("run_s", 0, -1, 4'b1000);
    nx(); mzero = 1'b1; chk("run_sm", 0, -1, 4'b1100);

    // Priority timeset over alarmset
    clr();
    nx(); timeset = 1'b1; alarmset = 1'b1; chk("pr1", 0, -1, -1);
    nx(); chk("pr2", 0, -1, -1);
    nx(); chk("pr3", 1, -1, -1);
    nx(); timeset = 1'b0; chk("pr4", 1, -1, -1);
    nx(); chk("pr5", 1, -1, -1);
    nx(); chk("pr6", 2, -1, -1);

    // Buzz length and no retrigger while match held
    clr();
    nx(); match = 1'b1; chk("bz1", 0, 1, -1);
    nx(); chk("bz2", -1, 1, -1);
    nx(); chk("bz3", -1, 1, -1);
    nx(); chk("bz4", -1, 1, -1);
    nx(); chk("bz_end", -1, 0, -1);
    nx(); chk("bz_hold1", -1, 0, -1);
    nx(); chk("bz_hold2", -1, 0, -1);
    nx(); match = 1'b0; chk("bz_low", -1, 0, -1);

    // alarmon cancel on the second buzz cycle
    nx(); match = 1'b1; chk("cn1", -1, 1, -1);
    nx(); chk("cn2", -1, 1, -1);
    nx(); alarmon = 1'b0; chk("cn_off", -1, 0, -1);
    nx(); alarmon = 1'b1; chk("cn_stay", -1, 0, -1);
    nx(); match = 1'b0; chk("cn_low", -1, 0, -1);

    // Restart on a new match edge while buzzing
    nx(); match = 1'b1; chk("rs1", -1, 1, -1);
    nx(); match = 1'b0; chk("rs2", -1, 1, -1);
    nx(); match = 1'b1; chk("rs3", -1, 1, -1);
    nx(); chk("rs4", -1, 1, -1);
    nx(); chk("rs5", -1, 1, -1);
    nx(); chk("rs6", -1, 1, -1);
    nx(); chk("rs7", -1, 0, -1);

    // No trigger outside RUN
    nx(); match = 1'b0; timeset = 1'b1; chk("tm1", -1, 0, -1);
    nx(); chk("tm2", -1, 0, -1);
    nx(); chk("tm3", 1, 0, -1);
    nx(); match = 1'b1; chk("tm4", 1, 0, -1);
    nx(); chk("tm5", 1, 0, -1);

    // Leaving RUN cancels an active buzz
    clr();
    nx(); match = 1'b1; timeset = 1'b1; chk("mc1", 0, 1, -1);
    nx(); chk("mc2", 0, 1, -1);
    nx(); chk("mc3", 1, 1, -1);
    nx(); chk("mc4", 1, 0, -1);

    // Reset mid-buzz
    clr();
    nx(); match = 1'b1; chk("rb1", 0, 1, -1);
    nx(); rst = 1'b0; chk("rb_rst", 0, 0, 4'b0000);
    nx(); rst = 1'b1; match = 1'b0;

    // Reset mid-debounce leaves no partial count
    clr();
    nx(); timeset = 1'b1; chk("rd1", 0, -1, -1);
    nx(); rst = 1'b0; chk("rd_rst", 0, -1, -1);
    nx(); rst = 1'b1; chk("rd2", 0, -1, -1);
    nx(); timeset = 1'b0; chk("rd3", 0, -1, -1);
    nx(); chk("rd4", 0, -1, -1);

    repeat (3) nx();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
